// File: rtl/hlrf_pkg.sv
// Shared definitions for the hconv-family raster sources: FSM encoding, pixel width
// and the flush-length formula.
package hlrf_pkg;
    localparam int PIX_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Zero beats needed to push the last hker-1 rows out of the convolver line buffers.
    function automatic int hflush_beats(input int len, input int ker);
        return (len + 1) * (ker - 1) + 1;
    endfunction
endpackage

// File: rtl/hraster_cnt.sv
// Raster position counters: column/row with wrap plus a running linear address.
// Wraps everything back to zero after the last pixel so the address idles at 0.
module hraster_cnt #(
    parameter logic [15:0] HIM_LEN = 16'd520,
    parameter logic [15:0] HIM_HT  = 16'd520,
    parameter int          ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              hres,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [15:0]       o_col,
    output logic [15:0]       o_row,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    logic [15:0]       r_col;
    logic [15:0]       r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              w_col_end;

    assign w_col_end = (r_col == HIM_LEN - 16'd1);
    assign o_last    = w_col_end && (r_row == HIM_HT - 16'd1);
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_addr    = r_addr;

    always_ff @(posedge clk or posedge hres) begin
        if (hres) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_clr || (i_adv && o_last)) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_adv) begin
            r_addr <= r_addr + 1'b1;
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 16'd1;
            end else begin
                r_col <= r_col + 16'd1;
            end
        end
    end
endmodule

// File: rtl/hraster_src8.sv
// Raster pixel source: streams one frame from a sync-read memory into an hconv
// convolver with row-end masks, then drains its line buffers with zero beats.
module hraster_src8
    import hlrf_pkg::*;
#(
    parameter logic [15:0] HIM_LEN = 16'd520,
    parameter logic [15:0] HIM_HT  = 16'd520,
    parameter logic [7:0]  hker    = 8'd3,
    parameter int          ADDR_W  = 19
) (
    input  logic                   clk,
    input  logic                   hres,
    input  logic                   hstart,
    output logic                   hren,
    output logic [ADDR_W-1:0]      hraddr,
    input  logic [PIX_W-1:0]       hrdata,
    output logic [PIX_W-1:0]       hin,
    output logic [int'(hker)-2:0]  hrowend,
    output logic                   hclrbuffer,
    output logic                   hvalid,
    output logic                   hbusy,
    output logic                   hdone
);
    localparam int          RE_W   = int'(hker) - 1;
    localparam int          HFLUSH = hflush_beats(int'(HIM_LEN), int'(hker));
    // FLUSH state spans 2 pipeline-drain cycles plus HFLUSH beats.
    localparam logic [15:0] FL_END = 16'(HFLUSH + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_nstate;
    logic [15:0]      r_fcnt;
    logic             r_s1_vld;
    logic [RE_W-1:0]  r_s1_re;
    logic [PIX_W-1:0] r_hin;
    logic [RE_W-1:0]  r_hre;
    logic             r_hvld;

    logic [15:0]      w_col;
    logic [15:0]      w_row;
    logic             w_last;
    logic             w_stream;
    logic             w_flush_beat;
    logic [RE_W-1:0]  w_re;

    assign w_stream = (r_state == ST_STREAM);

    hraster_cnt #(
        .HIM_LEN (HIM_LEN),
        .HIM_HT  (HIM_HT),
        .ADDR_W  (ADDR_W)
    ) u_cnt (
        .clk    (clk),
        .hres   (hres),
        .i_clr  (!w_stream),
        .i_adv  (w_stream),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_addr (hraddr),
        .o_last (w_last)
    );

    // Tap k reaches k+1 pixels ahead; mask it when that crosses the row end.
    for (genvar k = 0; k < RE_W; k++) begin : g_re
        assign w_re[k] = (int'(w_col) < int'(HIM_LEN) - 1 - k);
    end

    assign w_flush_beat = (r_state == ST_FLUSH) && (r_fcnt >= 16'd1) && (r_fcnt < FL_END);

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            ST_IDLE:   if (hstart) w_nstate = ST_CLEAR;
            ST_CLEAR:  w_nstate = ST_STREAM;
            ST_STREAM: if (w_last) w_nstate = ST_FLUSH;
            ST_FLUSH:  if (r_fcnt == FL_END) w_nstate = ST_DONE;
            ST_DONE:   w_nstate = ST_IDLE;
            default:   w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge hres) begin
        if (hres) begin
            r_state  <= ST_IDLE;
            r_fcnt   <= '0;
            r_s1_vld <= 1'b0;
            r_s1_re  <= '0;
            r_hin    <= '0;
            r_hre    <= '0;
            r_hvld   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_fcnt   <= (r_state == ST_FLUSH) ? r_fcnt + 16'd1 : 16'd0;
            r_s1_vld <= w_stream;
            r_s1_re  <= w_stream ? w_re : '0;
            r_hvld   <= r_s1_vld || w_flush_beat;
            r_hin    <= r_s1_vld ? hrdata : '0;
            if (r_s1_vld)
                r_hre <= r_s1_re;
            else if (w_flush_beat)
                r_hre <= '1;
            else
                r_hre <= '0;
        end
    end

    assign hren       = w_stream;
    assign hin        = r_hin;
    assign hrowend    = r_hre;
    assign hvalid     = r_hvld;
    assign hclrbuffer = (r_state == ST_CLEAR);
    assign hbusy      = (r_state == ST_CLEAR) || w_stream || (r_state == ST_FLUSH);
    assign hdone      = (r_state == ST_DONE);

    logic w_unused;
    assign w_unused = ^w_row;
endmodule

// File: tb/tb_hraster_src8.sv
// Directed bench for hraster_src8 on a 4x3 frame with mem[a] = a+1.
module tb_hraster_src8;
    localparam logic [15:0] L  = 16'd4;
    localparam logic [15:0] H  = 16'd3;
    localparam logic [7:0]  K  = 8'd3;
    localparam int          AW = 4;
    localparam int          NC = 28;

    typedef struct packed {
        logic        ren;
        logic [3:0]  addr;
        logic [7:0]  pix;
        logic [1:0]  re;
        logic        clr;
        logic        vld;
        logic        busy;
        logic        done;
    } rec_t;

    logic          clk = 1'b0;
    logic          hres = 1'b1;
    logic          hstart = 1'b0;
    logic          hren;
    logic [AW-1:0] hraddr;
    logic [7:0]    hrdata = '0;
    logic [7:0]    hin;
    logic [1:0]    hrowend;
    logic          hclrbuffer, hvalid, hbusy, hdone;

    int   checks = 0;
    int   failures = 0;
    logic [7:0] mem [0:15];
    rec_t vec [0:NC];

    hraster_src8 #(.HIM_LEN(L), .HIM_HT(H), .hker(K), .ADDR_W(AW)) dut (
        .clk(clk), .hres(hres), .hstart(hstart), .hren(hren), .hraddr(hraddr),
        .hrdata(hrdata), .hin(hin), .hrowend(hrowend), .hclrbuffer(hclrbuffer),
        .hvalid(hvalid), .hbusy(hbusy), .hdone(hdone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hren) hrdata <= mem[hraddr];

    function automatic rec_t cur();
        rec_t r;
        r = {hren, hraddr, hin, hrowend, hclrbuffer, hvalid, hbusy, hdone};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One frame checked cycle by cycle; an extra hstart pulse at cycle pulse_at must be ignored.
    task automatic run_frame(input string nm, input int pulse_at);
        @(negedge clk); hstart = 1'b1;
        for (int c = 1; c <= NC; c++) begin
            @(negedge clk);
            hstart = (c == pulse_at);
            chk($sformatf("%s c%0d", nm, c), 32'(cur()), 32'(vec[c]));
        end
        hstart = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'(a + 1);
        // Expected trace, cycle c counted from the edge that samples hstart.
        for (int c = 0; c <= NC; c++) begin
            rec_t r;
            int col;
            r = '0;
            r.busy = (c >= 1 && c <= 26);
            r.clr  = (c == 1);
            r.done = (c == 27);
            if (c >= 2 && c <= 13) begin
                r.ren  = 1'b1;
                r.addr = 4'(c - 2);
            end
            if (c >= 4 && c <= 15) begin
                col   = (c - 4) % 4;
                r.vld = 1'b1;
                r.pix = 8'(c - 3);
                r.re  = (col <= 1) ? 2'b11 : (col == 2) ? 2'b01 : 2'b00;
            end
            if (c >= 16 && c <= 26) begin
                r.vld = 1'b1;
                r.re  = 2'b11;
            end
            vec[c] = r;
        end

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(cur()), 32'h0);
        hres = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outputs", 32'(cur()), 32'h0);

        run_frame("frame", 0);
        run_frame("pulse_stream", 5);
        run_frame("pulse_done", 27);

        // Held-high hstart: one frame, next CLEAR only right after DONE.
        @(negedge clk); hstart = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            chk($sformatf("held c%0d", c), {30'd0, hclrbuffer, hdone},
                {30'd0, (c == 1 || c == 29), (c == 27)});
        end
        hstart = 1'b0;
        begin
            int n = 0;
            while (!hdone && n < 60) begin @(negedge clk); n++; end
            chk("held_second_done", 32'(hdone), 32'd1);
        end
        @(negedge clk);

        // Reset mid-STREAM aborts immediately and stays quiet.
        @(negedge clk); hstart = 1'b1;
        @(negedge clk); hstart = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_busy", 32'({hren, hbusy}), 32'h3);
        hres = 1'b1;
        #1;
        chk("abort_outputs", 32'(cur()), 32'h0);
        @(negedge clk); hres = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (hren || hbusy || hvalid) seen++;
            end
            chk("post_abort_quiet", seen, 0);
        end

        run_frame("recover", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
